// File: rtl/periph_init_sequencer.sv
// AXI4-Lite write-only master that replays a parameter table of register writes
// after reset or on request, with per-write timeout and error capture.
module periph_init_sequencer #(
   parameter int unsigned                  ADDR_W         = 32,
   parameter int unsigned                  DATA_W         = 32,
   parameter int unsigned                  NUM_WRITES     = 4,
   parameter logic [NUM_WRITES*ADDR_W-1:0] INIT_ADDR      = '0,
   parameter logic [NUM_WRITES*DATA_W-1:0] INIT_DATA      = '0,
   parameter int unsigned                  TIMEOUT_CYCLES = 1024,
   parameter bit                           AUTO_START     = 1'b1,
   parameter int unsigned                  IDX_W          = (NUM_WRITES > 1) ? $clog2(NUM_WRITES) : 1
) (
   input  logic                clk_i,
   input  logic                reset_i,
   input  logic                start_i,
   output logic                busy_o,
   output logic                done_o,
   output logic                error_o,
   output logic                err_timeout_o,
   output logic [IDX_W-1:0]    err_index_o,
   output logic [1:0]          err_resp_o,
   output logic [ADDR_W-1:0]   m_awaddr_o,
   output logic [2:0]          m_awprot_o,
   output logic                m_awvalid_o,
   input  logic                m_awready_i,
   output logic [DATA_W-1:0]   m_wdata_o,
   output logic [DATA_W/8-1:0] m_wstrb_o,
   output logic                m_wvalid_o,
   input  logic                m_wready_i,
   input  logic [1:0]          m_bresp_i,
   input  logic                m_bvalid_i,
   output logic                m_bready_o
);

   localparam int unsigned      CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WRITES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_B, S_DONE, S_ERROR} state_t;

   state_t              state_q, state_n;
   logic [IDX_W-1:0]    idx_q, idx_n;
   logic [CNT_W-1:0]    cnt_q, cnt_n;
   logic                pending_q, pending_n;
   logic                awvalid_q, awvalid_n;
   logic                wvalid_q, wvalid_n;
   logic                bready_q, bready_n;
   logic [ADDR_W-1:0]   awaddr_q, awaddr_n;
   logic [DATA_W-1:0]   wdata_q, wdata_n;
   logic                busy_q, busy_n;
   logic                done_q, done_n;
   logic                error_q, error_n;
   logic                err_timeout_q, err_timeout_n;
   logic [IDX_W-1:0]    err_index_q, err_index_n;
   logic [1:0]          err_resp_q, err_resp_n;

   logic b_hs, expired, aw_fin, w_fin;

   // A channel is finished once its valid has dropped or is being accepted now
   assign b_hs    = bready_q & m_bvalid_i;
   assign expired = (cnt_q == CNT_MAX);
   assign aw_fin  = ~awvalid_q | m_awready_i;
   assign w_fin   = ~wvalid_q | m_wready_i;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) state_q <= S_IDLE;
      else         state_q <= state_n;
   end

   // B handshake wins over an expiry in the same cycle
   always_comb begin
      state_n = state_q;
      case (state_q)
         S_IDLE:   if (pending_q || start_i) state_n = S_ISSUE;
         S_ISSUE: begin
            if (expired)             state_n = S_ERROR;
            else if (aw_fin && w_fin) state_n = S_WAIT_B;
         end
         S_WAIT_B: begin
            if (b_hs) begin
               if (m_bresp_i[1])           state_n = S_ERROR;
               else if (idx_q == LAST_IDX) state_n = S_DONE;
               else                        state_n = S_ISSUE;
            end else if (expired) begin
               state_n = S_ERROR;
            end
         end
         S_DONE, S_ERROR: if (start_i) state_n = S_ISSUE;
         default:  state_n = S_IDLE;
      endcase
   end

   always_comb begin
      idx_n         = idx_q;
      cnt_n         = cnt_q;
      pending_n     = pending_q;
      awvalid_n     = 1'b0;
      wvalid_n      = 1'b0;
      awaddr_n      = awaddr_q;
      wdata_n       = wdata_q;
      err_timeout_n = err_timeout_q;
      err_index_n   = err_index_q;
      err_resp_n    = err_resp_q;

      if (state_q == S_IDLE && state_n == S_ISSUE) pending_n = 1'b0;

      if (state_n == S_ISSUE) begin
         if (state_q == S_ISSUE) begin
            cnt_n     = cnt_q + CNT_W'(1);
            awvalid_n = awvalid_q & ~m_awready_i;
            wvalid_n  = wvalid_q & ~m_wready_i;
         end else begin
            idx_n     = (state_q == S_WAIT_B) ? idx_q + IDX_W'(1) : '0;
            cnt_n     = '0;
            awvalid_n = 1'b1;
            wvalid_n  = 1'b1;
            awaddr_n  = INIT_ADDR[32'(idx_n)*ADDR_W +: ADDR_W];
            wdata_n   = INIT_DATA[32'(idx_n)*DATA_W +: DATA_W];
         end
      end else if (state_n == S_WAIT_B) begin
         cnt_n = cnt_q + CNT_W'(1);
      end

      if (state_n == S_ERROR && state_q != S_ERROR) begin
         err_index_n   = idx_q;
         err_timeout_n = ~b_hs;
         err_resp_n    = b_hs ? m_bresp_i : 2'b00;
      end else if (state_n == S_ISSUE && (state_q == S_DONE || state_q == S_ERROR)) begin
         err_index_n   = '0;
         err_timeout_n = 1'b0;
         err_resp_n    = 2'b00;
      end

      bready_n = (state_n == S_WAIT_B);
      busy_n   = (state_n == S_ISSUE) || (state_n == S_WAIT_B);
      done_n   = (state_n == S_DONE);
      error_n  = (state_n == S_ERROR);
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         idx_q         <= '0;
         cnt_q         <= '0;
         pending_q     <= AUTO_START;
         awvalid_q     <= 1'b0;
         wvalid_q      <= 1'b0;
         bready_q      <= 1'b0;
         awaddr_q      <= '0;
         wdata_q       <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         error_q       <= 1'b0;
         err_timeout_q <= 1'b0;
         err_index_q   <= '0;
         err_resp_q    <= 2'b00;
      end else begin
         idx_q         <= idx_n;
         cnt_q         <= cnt_n;
         pending_q     <= pending_n;
         awvalid_q     <= awvalid_n;
         wvalid_q      <= wvalid_n;
         bready_q      <= bready_n;
         awaddr_q      <= awaddr_n;
         wdata_q       <= wdata_n;
         busy_q        <= busy_n;
         done_q        <= done_n;
         error_q       <= error_n;
         err_timeout_q <= err_timeout_n;
         err_index_q   <= err_index_n;
         err_resp_q    <= err_resp_n;
      end
   end

   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign error_o       = error_q;
   assign err_timeout_o = err_timeout_q;
   assign err_index_o   = err_index_q;
   assign err_resp_o    = err_resp_q;
   assign m_awaddr_o    = awaddr_q;
   assign m_awprot_o    = 3'b000;
   assign m_awvalid_o   = awvalid_q;
   assign m_wdata_o     = wdata_q;
   assign m_wstrb_o     = '1;
   assign m_wvalid_o    = wvalid_q;
   assign m_bready_o    = bready_q;

endmodule

// File: tb/tb_periph_init_sequencer.sv
// Bench for periph_init_sequencer: scoreboarded AXI4-Lite slave, response table,
// randomized delays/responses and hand-written timeout/reset/restart sequences.
`timescale 1ns/1ps
module tb_periph_init_sequencer;

   localparam int NW = 3;
   localparam int TO = 16;
   localparam logic [NW*32-1:0] T_ADDR = {32'h2000_0008, 32'h2000_0004, 32'h2000_0000};
   localparam logic [NW*32-1:0] T_DATA = {32'h0000_0001, 32'h0000_0003, 32'h0000_001B};

   logic        clk = 1'b0;
   logic        reset_i = 1'b1;
   logic        start_i = 1'b0;
   logic        busy_o, done_o, error_o, err_timeout_o;
   logic [1:0]  err_index_o, err_resp_o;
   logic [31:0] awaddr, wdata;
   logic [2:0]  awprot;
   logic [3:0]  wstrb;
   logic        awvalid, wvalid, bready;
   logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
   logic [1:0]  bresp = 2'b00;

   logic        start2 = 1'b0;
   logic        busy2, done2, error2, errto2, bready2, awvalid2, wvalid2;
   logic [0:0]  erridx2;
   logic [1:0]  errresp2;
   logic [31:0] awaddr2, wdata2;
   logic [2:0]  awprot2;
   logic [3:0]  wstrb2;

   always #5 clk = ~clk;

   periph_init_sequencer #(
      .ADDR_W(32), .DATA_W(32), .NUM_WRITES(NW), .INIT_ADDR(T_ADDR), .INIT_DATA(T_DATA),
      .TIMEOUT_CYCLES(TO), .AUTO_START(1'b1)
   ) u_dut (
      .clk_i(clk), .reset_i(reset_i), .start_i(start_i),
      .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .err_timeout_o(err_timeout_o),
      .err_index_o(err_index_o), .err_resp_o(err_resp_o),
      .m_awaddr_o(awaddr), .m_awprot_o(awprot), .m_awvalid_o(awvalid), .m_awready_i(awready),
      .m_wdata_o(wdata), .m_wstrb_o(wstrb), .m_wvalid_o(wvalid), .m_wready_i(wready),
      .m_bresp_i(bresp), .m_bvalid_i(bvalid), .m_bready_o(bready)
   );

   // Single-entry, manual-start instance against an always-ready slave
   periph_init_sequencer #(
      .ADDR_W(32), .DATA_W(32), .NUM_WRITES(1), .INIT_ADDR(32'h4000_0010), .INIT_DATA(32'h0000_00A5),
      .TIMEOUT_CYCLES(8), .AUTO_START(1'b0)
   ) u_man (
      .clk_i(clk), .reset_i(reset_i), .start_i(start2),
      .busy_o(busy2), .done_o(done2), .error_o(error2), .err_timeout_o(errto2),
      .err_index_o(erridx2), .err_resp_o(errresp2),
      .m_awaddr_o(awaddr2), .m_awprot_o(awprot2), .m_awvalid_o(awvalid2), .m_awready_i(1'b1),
      .m_wdata_o(wdata2), .m_wstrb_o(wstrb2), .m_wvalid_o(wvalid2), .m_wready_i(1'b1),
      .m_bresp_i(2'b00), .m_bvalid_i(1'b1), .m_bready_o(bready2)
   );

   logic [31:0] addr_tbl [NW] = '{32'h2000_0000, 32'h2000_0004, 32'h2000_0008};
   logic [31:0] data_tbl [NW] = '{32'h0000_001B, 32'h0000_0003, 32'h0000_0001};

   int          aw_dly [NW];
   int          w_dly  [NW];
   int          b_dly  [NW];
   bit          b_withhold [NW];
   logic [1:0]  resp_plan [NW];

   int          aw_cnt, w_cnt, b_cnt, viol;
   int          aw_wait, w_wait, b_timer;
   bit          b_armed, saw_aw_only, saw_w_only;
   logic        last_awvalid, last_wvalid, last_bready;
   logic [31:0] last_awaddr, last_wdata;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic reset_slave();
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; viol = 0;
      b_armed = 1'b0; bvalid = 1'b0; awready = 1'b0; wready = 1'b0;
      aw_wait = aw_dly[0]; w_wait = w_dly[0];
      last_awvalid = 1'b0; last_wvalid = 1'b0; last_bready = 1'b0;
      last_awaddr = '0; last_wdata = '0;
      saw_aw_only = 1'b0; saw_w_only = 1'b0;
   endtask

   task automatic zero_cfg();
      for (int k = 0; k < NW; k++) begin
         aw_dly[k] = 0; w_dly[k] = 0; b_dly[k] = 0; b_withhold[k] = 1'b0; resp_plan[k] = 2'b00;
      end
   endtask

   // Slave + scoreboard: at each falling edge, account for handshakes taken at the
   // previous rising edge, then decide the ready/valid levels for the next one.
   initial begin
      forever begin
         @(negedge clk);
         if (reset_i) begin
            awready = 1'b0; wready = 1'b0;
            last_awvalid = 1'b0; last_wvalid = 1'b0; last_bready = 1'b0;
         end else begin
            if (last_awvalid && awready) begin
               if (aw_cnt >= NW || last_awaddr !== addr_tbl[aw_cnt]) viol++;
               if (awvalid) viol++;
               aw_cnt++;
            end else if (last_awvalid && !error_o && (!awvalid || awaddr !== last_awaddr)) begin
               viol++;
            end
            if (last_wvalid && wready) begin
               if (w_cnt >= NW || last_wdata !== data_tbl[w_cnt] || wstrb !== 4'hF) viol++;
               if (wvalid) viol++;
               w_cnt++;
            end else if (last_wvalid && !error_o && (!wvalid || wdata !== last_wdata)) begin
               viol++;
            end
            if (last_bready && bvalid) begin
               b_cnt++;
               bvalid = 1'b0;
               b_armed = 1'b0;
            end
            if (awvalid && !wvalid) saw_aw_only = 1'b1;
            if (wvalid && !awvalid) saw_w_only = 1'b1;
            last_awvalid = awvalid; last_wvalid = wvalid; last_bready = bready;
            last_awaddr = awaddr; last_wdata = wdata;

            if (awvalid) begin
               if (aw_wait == 0) awready = 1'b1;
               else begin awready = 1'b0; aw_wait--; end
            end else begin
               awready = 1'b0;
               aw_wait = (aw_cnt < NW) ? aw_dly[aw_cnt] : 0;
            end
            if (wvalid) begin
               if (w_wait == 0) wready = 1'b1;
               else begin wready = 1'b0; w_wait--; end
            end else begin
               wready = 1'b0;
               w_wait = (w_cnt < NW) ? w_dly[w_cnt] : 0;
            end
            if (!b_armed && !bvalid && b_cnt < NW && aw_cnt == b_cnt + 1 && w_cnt == b_cnt + 1
                && !b_withhold[b_cnt]) begin
               b_armed = 1'b1;
               b_timer = b_dly[b_cnt];
            end
            if (b_armed && !bvalid) begin
               if (b_timer == 0) begin bvalid = 1'b1; bresp = resp_plan[b_cnt]; end
               else b_timer--;
            end
         end
      end
   end

   task automatic pulse_start();
      @(negedge clk); start_i = 1'b1;
      @(negedge clk); start_i = 1'b0;
   endtask

   task automatic wait_end(input int budget, output int cycles);
      cycles = 0;
      while (!(done_o || error_o) && cycles < budget) begin
         @(negedge clk);
         cycles++;
      end
      if (!(done_o || error_o)) check("end_reached", 64'(0), 64'(1));
   endtask

   // One restarted sequence with the currently configured delays and given responses
   task automatic run_seq(input string tag, input logic [5:0] rp, input bit e_done, input bit e_err,
                          input int e_idx, input logic [1:0] e_resp, input int e_aw);
      int cyc;
      @(negedge clk); #2;
      for (int k = 0; k < NW; k++) resp_plan[k] = rp[2*k +: 2];
      reset_slave();
      pulse_start();
      check({tag, "_start_busy"}, 64'(busy_o), 64'(1));
      check({tag, "_start_clr"}, 64'({error_o, err_timeout_o, err_index_o, err_resp_o}), 64'(0));
      wait_end(200, cyc);
      repeat (3) @(negedge clk);
      check({tag, "_done"}, 64'(done_o), 64'(e_done));
      check({tag, "_error"}, 64'(error_o), 64'(e_err));
      check({tag, "_err_index"}, 64'(err_index_o), 64'(e_idx));
      check({tag, "_err_resp"}, 64'(err_resp_o), 64'(e_resp));
      check({tag, "_err_timeout"}, 64'(err_timeout_o), 64'(0));
      check({tag, "_busy_after"}, 64'(busy_o), 64'(0));
      check({tag, "_aw_count"}, 64'(aw_cnt), 64'(e_aw));
      check({tag, "_b_count"}, 64'(b_cnt), 64'(e_aw));
      check({tag, "_protocol"}, 64'(viol), 64'(0));
   endtask

   typedef struct {
      logic [5:0] rp;
      bit         e_done;
      bit         e_err;
      int         e_idx;
      logic [1:0] e_resp;
      int         e_aw;
   } row_t;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      row_t       rows [6];
      int         cyc, first_err, v;
      logic [5:0] rp;
      logic [1:0] r;

      // responses packed {entry2, entry1, entry0}
      rows[0] = '{6'b00_00_00, 1'b1, 1'b0, 0, 2'b00, 3};
      rows[1] = '{6'b00_01_00, 1'b1, 1'b0, 0, 2'b00, 3};
      rows[2] = '{6'b00_00_10, 1'b0, 1'b1, 0, 2'b10, 1};
      rows[3] = '{6'b00_11_00, 1'b0, 1'b1, 1, 2'b11, 2};
      rows[4] = '{6'b10_00_00, 1'b0, 1'b1, 2, 2'b10, 3};
      rows[5] = '{6'b01_01_01, 1'b1, 1'b0, 0, 2'b00, 3};

      zero_cfg();
      reset_slave();
      repeat (3) @(negedge clk);
      check("rst_status", 64'({busy_o, done_o, error_o, err_timeout_o, err_index_o, err_resp_o}), 64'(0));
      check("rst_bus", 64'({awvalid, wvalid, bready}), 64'(0));
      check("rst_addr", 64'(awaddr), 64'(0));
      check("rst_data", 64'(wdata), 64'(0));

      // auto-start with a zero-wait slave
      reset_i = 1'b0;
      @(negedge clk);
      check("auto_valids", 64'({awvalid, wvalid}), 64'(2'b11));
      check("auto_addr0", 64'(awaddr), 64'(32'h2000_0000));
      check("auto_data0", 64'(wdata), 64'(32'h1B));
      check("auto_const", 64'({awprot, wstrb}), 64'(7'b000_1111));
      repeat (5) @(negedge clk);
      check("auto_done_c6", 64'(done_o), 64'(0));
      @(negedge clk);
      check("auto_done_c7", 64'(done_o), 64'(1));
      check("auto_busy_c7", 64'(busy_o), 64'(0));
      repeat (2) @(negedge clk);
      check("auto_aw_count", 64'(aw_cnt), 64'(3));
      check("auto_protocol", 64'(viol), 64'(0));

      // response table, each row restarted from the previous DONE/ERROR
      for (int i = 0; i < 6; i++)
         run_seq($sformatf("row%0d", i), rows[i].rp, rows[i].e_done, rows[i].e_err,
                 rows[i].e_idx, rows[i].e_resp, rows[i].e_aw);

      // skewed handshakes
      aw_dly[0] = 0; w_dly[0] = 3; aw_dly[1] = 3; w_dly[1] = 0;
      run_seq("skew", 6'b00_00_00, 1'b1, 1'b0, 0, 2'b00, 3);
      check("skew_aw_only", 64'(saw_aw_only), 64'(1));
      check("skew_w_only", 64'(saw_w_only), 64'(1));
      zero_cfg();

      // randomized delays and responses against the first-error reference model
      for (int it = 0; it < 25; it++) begin
         for (int k = 0; k < NW; k++) begin
            aw_dly[k] = $urandom_range(0, 3);
            w_dly[k]  = $urandom_range(0, 3);
            b_dly[k]  = $urandom_range(0, 4);
            v = $urandom_range(0, 7);
            r = (v < 3) ? 2'b00 : (v < 6) ? 2'b01 : (v == 6) ? 2'b10 : 2'b11;
            rp[2*k +: 2] = r;
         end
         first_err = -1;
         for (int k = 0; k < NW; k++)
            if (first_err < 0 && rp[2*k+1]) first_err = k;
         run_seq($sformatf("rnd%0d", it), rp, first_err < 0, first_err >= 0,
                 (first_err < 0) ? 0 : first_err,
                 (first_err < 0) ? 2'b00 : rp[2*((first_err < 0) ? 0 : first_err) +: 2],
                 (first_err < 0) ? NW : first_err + 1);
      end
      zero_cfg();

      // timeout in WAIT_B with bvalid withheld
      @(negedge clk); #2;
      b_withhold[0] = 1'b1;
      reset_slave();
      pulse_start();
      repeat (15) @(negedge clk);
      check("to_c15_error", 64'(error_o), 64'(0));
      check("to_c15_bready", 64'(bready), 64'(1));
      @(negedge clk);
      check("to_c16_error", 64'(error_o), 64'(1));
      check("to_c16_flag", 64'(err_timeout_o), 64'(1));
      check("to_c16_fields", 64'({err_index_o, err_resp_o}), 64'(0));
      check("to_c16_bus", 64'({awvalid, wvalid, bready, busy_o}), 64'(0));
      zero_cfg();

      // timeout in ISSUE with awready never given
      @(negedge clk); #2;
      aw_dly[0] = 40;
      reset_slave();
      pulse_start();
      check("toi_start_clr", 64'({error_o, err_timeout_o}), 64'(0));
      repeat (15) @(negedge clk);
      check("toi_c15_awvalid", 64'(awvalid), 64'(1));
      @(negedge clk);
      check("toi_c16_status", 64'({error_o, err_timeout_o, err_index_o}), 64'({1'b1, 1'b1, 2'd0}));
      check("toi_c16_awvalid", 64'(awvalid), 64'(0));
      zero_cfg();

      // bvalid on the expiry cycle still advances
      @(negedge clk); #2;
      b_dly[0] = 14;
      reset_slave();
      pulse_start();
      repeat (16) @(negedge clk);
      check("edge_c16_error", 64'(error_o), 64'(0));
      check("edge_c16_issue", 64'({awvalid, busy_o}), 64'(2'b11));
      check("edge_c16_addr1", 64'(awaddr), 64'(32'h2000_0004));
      wait_end(100, cyc);
      check("edge_done", 64'(done_o), 64'(1));
      zero_cfg();

      // start while busy is ignored
      @(negedge clk); #2;
      reset_slave();
      pulse_start();
      repeat (2) @(negedge clk);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      wait_end(100, cyc);
      check("busy_start_cycles", 64'(cyc), 64'(3));
      repeat (2) @(negedge clk);
      check("busy_start_aw", 64'(aw_cnt), 64'(3));

      // asynchronous reset in WAIT_B, then auto restart from entry 0
      @(negedge clk); #2;
      b_withhold[0] = 1'b1;
      reset_slave();
      pulse_start();
      cyc = 0;
      while (!bready && cyc < 20) begin @(negedge clk); cyc++; end
      check("mid_reached_waitb", 64'(bready), 64'(1));
      reset_i = 1'b1;
      #1;
      check("mid_rst_status", 64'({busy_o, done_o, error_o, err_timeout_o, err_index_o, err_resp_o}), 64'(0));
      check("mid_rst_bus", 64'({awvalid, wvalid, bready}), 64'(0));
      check("mid_rst_addr_data", 64'({awaddr, wdata}), 64'(0));
      #1;
      zero_cfg();
      reset_slave();
      @(negedge clk);
      reset_i = 1'b0;
      @(negedge clk);
      check("mid_restart_valid", 64'(awvalid), 64'(1));
      check("mid_restart_addr", 64'(awaddr), 64'(32'h2000_0000));
      wait_end(100, cyc);
      check("mid_restart_done", 64'(done_o), 64'(1));

      // manual-start instance stays idle until start
      repeat (4) @(negedge clk);
      check("man_idle", 64'({busy2, done2, error2, awvalid2}), 64'(0));
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      check("man_issue", 64'({busy2, awvalid2, wvalid2}), 64'(3'b111));
      check("man_addr_data", 64'({awaddr2, wdata2}), 64'({32'h4000_0010, 32'h0000_00A5}));
      check("man_const", 64'({awprot2, wstrb2}), 64'(7'b000_1111));
      @(negedge clk);
      check("man_waitb", 64'({bready2, awvalid2}), 64'(2'b10));
      @(negedge clk);
      check("man_done", 64'({done2, busy2, error2, errto2, erridx2, errresp2}), 64'(7'b100_0000));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
